// File: rtl/csa_pkg.sv
// Shared constants and sizing helper for the carry-select adder.
package csa_pkg;

    localparam int unsigned CSA_DEFAULT_N     = 4;
    localparam int unsigned CSA_DEFAULT_BLOCK = 4;

    function automatic int unsigned csa_num_blocks(input int unsigned n, input int unsigned blk);
        return (n + blk - 1) / blk;
    endfunction

endpackage

// File: rtl/ripple_carry_block.sv
// W-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_block #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[W];

endmodule

// File: rtl/carry_select_adder.sv
// N-bit carry-select adder; define CARRY_SELECT_ADDER_OUTREG_EN to register
// sum/cout (one cycle latency, async active-low reset clears them).
module carry_select_adder
    import csa_pkg::*;
#(
    parameter int unsigned N     = CSA_DEFAULT_N,
    parameter int unsigned BLOCK = CSA_DEFAULT_BLOCK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned BW = (BLOCK > N) ? N : BLOCK;
    localparam int unsigned NB = csa_num_blocks(N, BW);

    logic [N-1:0] w_sum;
    logic         w_cout;

    // Each block keeps its own carry so the select chain is a plain mux ladder.
    for (genvar g = 0; g < NB; g++) begin : blk
        localparam int unsigned LO = g * BW;
        localparam int unsigned W  = (g == NB - 1) ? (N - LO) : BW;

        logic w_cout;

        if (g == 0) begin : g_first
            ripple_carry_block #(.W(W)) u_rcb (
                .a    (a[LO +: W]),
                .b    (b[LO +: W]),
                .cin  (cin),
                .sum  (w_sum[LO +: W]),
                .cout (w_cout)
            );
        end else begin : g_sel
            logic [W-1:0] w_s0;
            logic [W-1:0] w_s1;
            logic         w_c0;
            logic         w_c1;

            ripple_carry_block #(.W(W)) u_rcb0 (
                .a    (a[LO +: W]),
                .b    (b[LO +: W]),
                .cin  (1'b0),
                .sum  (w_s0),
                .cout (w_c0)
            );
            ripple_carry_block #(.W(W)) u_rcb1 (
                .a    (a[LO +: W]),
                .b    (b[LO +: W]),
                .cin  (1'b1),
                .sum  (w_s1),
                .cout (w_c1)
            );

            assign w_sum[LO +: W] = blk[g-1].w_cout ? w_s1 : w_s0;
            assign w_cout         = blk[g-1].w_cout ? w_c1 : w_c0;
        end
    end

    assign w_cout = blk[NB-1].w_cout;

`ifdef CARRY_SELECT_ADDER_OUTREG_EN
    logic [N-1:0] r_sum;
    logic         r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`else
    logic w_unused;
    assign w_unused = clk ^ rst_n;

    assign sum  = w_sum;
    assign cout = w_cout;
`endif

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench: many parameterisations driven from shared inputs,
// checked against an arithmetic model plus hand-computed directed vectors.
module tb_carry_select_adder;

    localparam int unsigned NCFG = 23;
    localparam int unsigned NS [NCFG] = '{1, 8, 7,
                                          1, 1, 1, 1,
                                          5, 5, 5, 5,
                                          8, 8, 8, 8,
                                          16, 16, 16, 16,
                                          32, 32, 32, 32};
    localparam int unsigned BS [NCFG] = '{4, 4, 3,
                                          1, 2, 4, 2,
                                          1, 2, 4, 6,
                                          1, 2, 4, 9,
                                          1, 2, 4, 17,
                                          1, 2, 4, 33};

    logic        clk;
    logic        rst_n;
    logic [31:0] t_a;
    logic [31:0] t_b;
    logic        t_cin;
    logic        check_en;
    logic [32:0] res [NCFG];

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : dut
        localparam int unsigned GN = NS[g];
        localparam int unsigned GB = BS[g];
        logic [GN-1:0] w_s;
        logic          w_c;

        carry_select_adder #(.N(GN), .BLOCK(GB)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (t_a[GN-1:0]),
            .b     (t_b[GN-1:0]),
            .cin   (t_cin),
            .sum   (w_s),
            .cout  (w_c)
        );

        assign res[g] = 33'(w_s) | (33'(w_c) << GN);
    end

    function automatic logic [32:0] model(input int unsigned n, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] m;
        logic [32:0] r;
        m = (33'h1 << n) - 33'h1;
        r = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'b0, c};
        return r & ((m << 1) | 33'h1);
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {cout,sum}=0x%0h expected 0x%0h (a=0x%0h b=0x%0h cin=%0b)",
                     name, act, exp, t_a, t_b, t_cin);
        end
    endtask

    task automatic compare_all();
        for (int unsigned i = 0; i < NCFG; i++)
            chk($sformatf("model N=%0d BLOCK=%0d", NS[i], BS[i]), res[i],
                model(NS[i], t_a, t_b, t_cin));
    endtask

    // Outputs are meaningful 1 time unit after each rising edge in both builds.
    always @(posedge clk) begin
        #1;
        if (check_en) compare_all();
    end

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        t_a   = a;
        t_b   = b;
        t_cin = c;
        @(posedge clk);
        #2;
    endtask

    task automatic dir(input string name, input int unsigned idx, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic [32:0] exp);
        apply(a, b, c);
        chk(name, res[idx], exp);
    endtask

    task automatic reset_check(input string name);
`ifdef CARRY_SELECT_ADDER_OUTREG_EN
        for (int unsigned i = 0; i < NCFG; i++)
            chk($sformatf("%s N=%0d", name, NS[i]), res[i], 33'h0);
`else
        for (int unsigned i = 0; i < NCFG; i++)
            chk($sformatf("%s N=%0d", name, NS[i]), res[i], model(NS[i], t_a, t_b, t_cin));
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        check_en = 1'b0;
        rst_n    = 1'b0;
        t_a      = 32'h0F;
        t_b      = 32'h01;
        t_cin    = 1'b0;

        #3;
        reset_check("reset_state");
        #97;
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;

        dir("n1_010", 0, 32'h0, 32'h1, 1'b0, 33'h1);
        dir("n1_100", 0, 32'h1, 32'h0, 1'b0, 33'h1);
        dir("n1_001", 0, 32'h0, 32'h0, 1'b1, 33'h1);
        dir("n1_101", 0, 32'h1, 32'h0, 1'b1, 33'h2);
        dir("n1_011", 0, 32'h0, 32'h1, 1'b1, 33'h2);
        dir("n1_111", 0, 32'h1, 32'h1, 1'b1, 33'h3);
        dir("n1_110", 0, 32'h1, 32'h1, 1'b0, 33'h2);
        dir("n1_000", 0, 32'h0, 32'h0, 1'b0, 33'h0);

        dir("n8_boundary", 1, 32'h0F, 32'h01, 1'b0, 33'h010);
        dir("n8_allcarry", 1, 32'hFF, 32'h00, 1'b1, 33'h100);
        dir("n7_ragged_max", 2, 32'h7F, 32'h7F, 1'b1, 33'h0FF);
        dir("n7_ragged_nc", 2, 32'h40, 32'h3F, 1'b0, 33'h07F);
        dir("n8_msb_carry", 1, 32'h80, 32'h80, 1'b0, 33'h100);

        // Mid-stream reset: registered build clears, combinational build ignores it.
        @(negedge clk);
        t_a      = 32'hDEADBEEF;
        t_b      = 32'h12345678;
        t_cin    = 1'b1;
        @(posedge clk);
        #3;
        check_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        reset_check("midstream_reset");
        @(negedge clk);
        #1;
        reset_check("reset_held");
        rst_n    = 1'b1;
        check_en = 1'b1;

        dir("n8_after_reset", 1, 32'hF0, 32'h0F, 1'b1, 33'h100);
        dir("n32_wrap", 19, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h100000000);

        for (int i = 0; i < 1000; i++)
            apply($urandom, $urandom, 1'($urandom_range(0, 1)));

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
